// File: rtl/tetron_rotator.sv
// Active tetromino holder: registered block offsets for all seven pieces, rotation
// requests resolved through a probe handshake with a horizontal wall-kick search.
//
// state | meaning
// IDLE  | committed piece stable; accepts load and rotation requests
// PROBE | candidate rotation presented to the checker, stepping through kicks
module tetron_rotator #(
   parameter int OFF_W = 5,
   parameter int KICKS = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    active,
   input  logic                    load,
   input  logic [2:0]              load_type,
   input  logic                    rot_cw,
   input  logic                    rot_ccw,
   output logic                    probe_valid,
   output logic signed [OFF_W-1:0] probe_blk1_voffset,
   output logic signed [OFF_W-1:0] probe_blk1_hoffset,
   output logic signed [OFF_W-1:0] probe_blk2_voffset,
   output logic signed [OFF_W-1:0] probe_blk2_hoffset,
   output logic signed [OFF_W-1:0] probe_blk3_voffset,
   output logic signed [OFF_W-1:0] probe_blk3_hoffset,
   output logic signed [OFF_W-1:0] probe_blk4_voffset,
   output logic signed [OFF_W-1:0] probe_blk4_hoffset,
   output logic signed [OFF_W-1:0] probe_hshift,
   input  logic                    probe_ack,
   input  logic                    probe_free,
   output logic signed [OFF_W-1:0] blk1_voffset,
   output logic signed [OFF_W-1:0] blk1_hoffset,
   output logic signed [OFF_W-1:0] blk2_voffset,
   output logic signed [OFF_W-1:0] blk2_hoffset,
   output logic signed [OFF_W-1:0] blk3_voffset,
   output logic signed [OFF_W-1:0] blk3_hoffset,
   output logic signed [OFF_W-1:0] blk4_voffset,
   output logic signed [OFF_W-1:0] blk4_hoffset,
   output logic [1:0]              rotation,
   output logic signed [OFF_W-1:0] kick_hshift,
   output logic                    busy,
   output logic                    done,
   output logic                    rot_ok
);

   typedef enum logic {IDLE = 1'b0, PROBE = 1'b1} state_t;

   localparam logic [2:0] T_O   = 3'd1;
   localparam logic [2:0] T_BAD = 3'd7;
   localparam logic [2:0] Z0 = 3'b000, P1 = 3'b001, P2 = 3'b010, M1 = 3'b111;

   // Offsets are kept as 3-bit signed (v,h) pairs, blk1 in the top six bits.
   function automatic logic [23:0] shape0(input logic [2:0] t);
      case (t)
         3'd0:    shape0 = {Z0, Z0, Z0, M1, Z0, P1, Z0, P2};
         3'd1:    shape0 = {Z0, Z0, Z0, P1, P1, Z0, P1, P1};
         3'd2:    shape0 = {Z0, Z0, Z0, M1, Z0, P1, M1, Z0};
         3'd3:    shape0 = {Z0, Z0, Z0, M1, M1, Z0, M1, P1};
         3'd4:    shape0 = {Z0, Z0, Z0, P1, M1, Z0, M1, M1};
         3'd5:    shape0 = {Z0, Z0, Z0, M1, Z0, P1, M1, M1};
         3'd6:    shape0 = {Z0, Z0, Z0, M1, Z0, P1, M1, P1};
         default: shape0 = '0;
      endcase
   endfunction

   function automatic logic [23:0] shape(input logic [2:0] t, input logic [1:0] r);
      logic [23:0] s;
      logic [2:0]  v;
      logic [2:0]  h;
      s = shape0(t);
      if (t != T_O)
         for (int i = 0; i < 3; i++)
            if (i < int'(r))
               for (int b = 0; b < 4; b++) begin
                  v = s[b*6+3 +: 3];
                  h = s[b*6 +: 3];
                  s[b*6+3 +: 3] = h;
                  s[b*6 +: 3]   = 3'd0 - v;
               end
      return s;
   endfunction

   function automatic logic signed [OFF_W-1:0] kick(input logic [2:0] n);
      case (n)
         3'd1:    kick = OFF_W'(-1);
         3'd2:    kick = OFF_W'(1);
         3'd3:    kick = OFF_W'(-2);
         3'd4:    kick = OFF_W'(2);
         default: kick = '0;
      endcase
   endfunction

   function automatic logic signed [OFF_W-1:0] sx(input logic [2:0] x);
      return OFF_W'($signed(x));
   endfunction

   state_t      state;
   logic [2:0]  ptype;
   logic [2:0]  k;
   logic [1:0]  cand_rot;
   logic [1:0]  next_rot;
   logic [23:0] cur;
   logic [23:0] cand;

   assign next_rot = rot_cw ? rotation + 2'd1 : rotation - 2'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         ptype        <= T_O;
         k            <= '0;
         cand_rot     <= '0;
         cur          <= '0;
         cand         <= '0;
         rotation     <= '0;
         kick_hshift  <= '0;
         probe_hshift <= '0;
         probe_valid  <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         rot_ok       <= 1'b0;
      end else if (!active) begin
         state        <= IDLE;
         ptype        <= T_O;
         k            <= '0;
         cand_rot     <= '0;
         cur          <= '0;
         cand         <= '0;
         rotation     <= '0;
         kick_hshift  <= '0;
         probe_hshift <= '0;
         probe_valid  <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         rot_ok       <= 1'b0;
      end else begin
         done   <= 1'b0;
         rot_ok <= 1'b0;
         if (load && load_type != T_BAD) begin
            // A load also abandons any outstanding probe without a done pulse.
            ptype       <= load_type;
            rotation    <= '0;
            cur         <= shape(load_type, 2'd0);
            kick_hshift <= '0;
            k           <= '0;
            probe_valid <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (rot_cw ^ rot_ccw) begin
                     if (ptype == T_O) begin
                        rotation    <= next_rot;
                        kick_hshift <= '0;
                        done        <= 1'b1;
                        rot_ok      <= 1'b1;
                     end else begin
                        cand_rot     <= next_rot;
                        cand         <= shape(ptype, next_rot);
                        k            <= '0;
                        probe_hshift <= kick(3'd0);
                        probe_valid  <= 1'b1;
                        busy         <= 1'b1;
                        state        <= PROBE;
                     end
                  end
               end
               PROBE: begin
                  if (probe_ack) begin
                     if (probe_free) begin
                        rotation    <= cand_rot;
                        cur         <= cand;
                        kick_hshift <= probe_hshift;
                        done        <= 1'b1;
                        rot_ok      <= 1'b1;
                        probe_valid <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                     end else if (k == 3'(KICKS-1)) begin
                        done        <= 1'b1;
                        probe_valid <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                     end else begin
                        k            <= k + 3'd1;
                        probe_hshift <= kick(k + 3'd1);
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign blk1_voffset = sx(cur[21 +: 3]);
   assign blk1_hoffset = sx(cur[18 +: 3]);
   assign blk2_voffset = sx(cur[15 +: 3]);
   assign blk2_hoffset = sx(cur[12 +: 3]);
   assign blk3_voffset = sx(cur[9 +: 3]);
   assign blk3_hoffset = sx(cur[6 +: 3]);
   assign blk4_voffset = sx(cur[3 +: 3]);
   assign blk4_hoffset = sx(cur[0 +: 3]);

   assign probe_blk1_voffset = sx(cand[21 +: 3]);
   assign probe_blk1_hoffset = sx(cand[18 +: 3]);
   assign probe_blk2_voffset = sx(cand[15 +: 3]);
   assign probe_blk2_hoffset = sx(cand[12 +: 3]);
   assign probe_blk3_voffset = sx(cand[9 +: 3]);
   assign probe_blk3_hoffset = sx(cand[6 +: 3]);
   assign probe_blk4_voffset = sx(cand[3 +: 3]);
   assign probe_blk4_hoffset = sx(cand[0 +: 3]);

endmodule

// File: tb/tb_tetron_rotator.sv
// Randomised bench for tetron_rotator: reference model of piece tables and kick
// search, expected done-events queued at stimulus time and checked by a monitor.
module tb_tetron_rotator;
   localparam int OFF_W = 5;
   localparam int KICKS = 3;

   localparam int BV[7][4] = '{'{0,0,0,0}, '{0,0,1,1}, '{0,0,0,-1}, '{0,0,-1,-1},
                               '{0,0,-1,-1}, '{0,0,0,-1}, '{0,0,0,-1}};
   localparam int BH[7][4] = '{'{0,-1,1,2}, '{0,1,0,1}, '{0,-1,1,0}, '{0,-1,0,1},
                               '{0,1,0,-1}, '{0,-1,1,-1}, '{0,-1,1,1}};
   localparam int KSEQ[5] = '{0, -1, 1, -2, 2};

   logic clk = 1'b0, rst_n = 1'b0, active = 1'b0, load = 1'b0;
   logic rot_cw = 1'b0, rot_ccw = 1'b0, probe_ack = 1'b0, probe_free = 1'b0;
   logic [2:0] load_type = 3'd0;
   logic probe_valid, busy, done, rot_ok;
   logic [1:0] rotation;
   logic signed [OFF_W-1:0] probe_hshift, kick_hshift;
   logic signed [OFF_W-1:0] dv[4], dh[4], pv[4], ph[4];

   tetron_rotator #(.OFF_W(OFF_W), .KICKS(KICKS)) dut (
      .clk(clk), .rst_n(rst_n), .active(active), .load(load), .load_type(load_type),
      .rot_cw(rot_cw), .rot_ccw(rot_ccw), .probe_valid(probe_valid),
      .probe_blk1_voffset(pv[0]), .probe_blk1_hoffset(ph[0]),
      .probe_blk2_voffset(pv[1]), .probe_blk2_hoffset(ph[1]),
      .probe_blk3_voffset(pv[2]), .probe_blk3_hoffset(ph[2]),
      .probe_blk4_voffset(pv[3]), .probe_blk4_hoffset(ph[3]),
      .probe_hshift(probe_hshift), .probe_ack(probe_ack), .probe_free(probe_free),
      .blk1_voffset(dv[0]), .blk1_hoffset(dh[0]), .blk2_voffset(dv[1]), .blk2_hoffset(dh[1]),
      .blk3_voffset(dv[2]), .blk3_hoffset(dh[2]), .blk4_voffset(dv[3]), .blk4_hoffset(dh[3]),
      .rotation(rotation), .kick_hshift(kick_hshift), .busy(busy), .done(done), .rot_ok(rot_ok)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        ok;
      logic [1:0]  rot;
      logic [31:0] offs;
      int          kick;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int n_vec = 0, n_err = 0;
   int mtype, mrot, mkick;
   int mv[4], mh[4], cv[4], ch[4];

   task automatic chk(input string nm, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d", nm, act, req);
      end
   endtask

   // Piece offsets at rotation r: table-0 entry turned clockwise r times, (v,h)->(h,-v).
   function automatic void model_shape(input int t, input int r);
      int tmp;
      for (int b = 0; b < 4; b++) begin
         cv[b] = BV[t][b];
         ch[b] = BH[t][b];
         if (t != 1)
            for (int i = 0; i < r; i++) begin
               tmp = cv[b]; cv[b] = ch[b]; ch[b] = -tmp;
            end
      end
   endfunction

   function automatic void model_reset();
      mtype = 1; mrot = 0; mkick = 0;
      for (int b = 0; b < 4; b++) begin mv[b] = 0; mh[b] = 0; end
   endfunction

   function automatic logic [31:0] pack_model();
      logic [31:0] p;
      p = '0;
      for (int b = 0; b < 4; b++) begin
         p[b*8 +: 4]   = 4'(mv[b]);
         p[b*8+4 +: 4] = 4'(mh[b]);
      end
      return p;
   endfunction

   function automatic int nib(input logic [31:0] p, input int i);
      return int'($signed(p[i*4 +: 4]));
   endfunction

   task automatic push(input int ok);
      exp_t e;
      e.ok = (ok != 0);
      e.rot = 2'(mrot);
      e.offs = pack_model();
      e.kick = mkick;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_done: got done=1 required no done");
         end else begin
            mon_e = exp_q.pop_front();
            chk("done_rot_ok", int'(rot_ok), int'(mon_e.ok));
            chk("done_rotation", int'(rotation), int'(mon_e.rot));
            chk("done_kick_hshift", int'(kick_hshift), mon_e.kick);
            for (int b = 0; b < 4; b++) begin
               chk("done_blk_v", int'(dv[b]), nib(mon_e.offs, 2*b));
               chk("done_blk_h", int'(dh[b]), nib(mon_e.offs, 2*b+1));
            end
         end
      end
   end

   task automatic check_state(input string nm);
      chk({nm, "_rotation"}, int'(rotation), mrot);
      chk({nm, "_kick"}, int'(kick_hshift), mkick);
      chk({nm, "_busy"}, int'(busy), 0);
      chk({nm, "_probe_valid"}, int'(probe_valid), 0);
      for (int b = 0; b < 4; b++) begin
         chk({nm, "_blk_v"}, int'(dv[b]), mv[b]);
         chk({nm, "_blk_h"}, int'(dh[b]), mh[b]);
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_probe_valid"}, int'(probe_valid), 0);
      chk({nm, "_busy"}, int'(busy), 0);
      chk({nm, "_done"}, int'(done), 0);
      chk({nm, "_rot_ok"}, int'(rot_ok), 0);
      chk({nm, "_rotation"}, int'(rotation), 0);
      chk({nm, "_kick"}, int'(kick_hshift), 0);
      chk({nm, "_probe_hshift"}, int'(probe_hshift), 0);
      for (int b = 0; b < 4; b++) begin
         chk({nm, "_blk_v"}, int'(dv[b]), 0);
         chk({nm, "_blk_h"}, int'(dh[b]), 0);
         chk({nm, "_probe_v"}, int'(pv[b]), 0);
         chk({nm, "_probe_h"}, int'(ph[b]), 0);
      end
   endtask

   task automatic chk_probe(input int k);
      chk("probe_valid", int'(probe_valid), 1);
      chk("probe_busy", int'(busy), 1);
      chk("probe_hshift", int'(probe_hshift), KSEQ[k]);
      for (int b = 0; b < 4; b++) begin
         chk("probe_blk_v", int'(pv[b]), cv[b]);
         chk("probe_blk_h", int'(ph[b]), ch[b]);
      end
   endtask

   task automatic do_load(input int t);
      load = 1'b1;
      load_type = 3'(t);
      @(negedge clk);
      load = 1'b0;
      if (t != 7) begin
         mtype = t; mrot = 0; mkick = 0;
         model_shape(t, 0);
         mv = cv; mh = ch;
      end
      check_state("load");
   endtask

   task automatic do_rot(input int ccw, input int nfail);
      int nr;
      bit fr;
      nr = (mrot + ((ccw != 0) ? 3 : 1)) % 4;
      if (mtype == 1) begin
         mrot = nr; mkick = 0;
         push(1);
      end
      rot_cw = (ccw == 0);
      rot_ccw = (ccw != 0);
      @(negedge clk);
      rot_cw = 1'b0;
      rot_ccw = 1'b0;
      if (mtype == 1) begin
         chk("o_no_probe", int'(probe_valid), 0);
         chk("o_not_busy", int'(busy), 0);
         return;
      end
      model_shape(mtype, nr);
      for (int k = 0; k < KICKS; k++) begin
         chk_probe(k);
         if ($urandom_range(0, 2) == 0) begin
            @(negedge clk);
            chk_probe(k);
         end
         fr = (k >= nfail);
         if (fr) begin
            mrot = nr; mv = cv; mh = ch; mkick = KSEQ[k];
            push(1);
         end else if (k == KICKS-1) begin
            push(0);
         end
         probe_ack = 1'b1;
         probe_free = fr;
         @(negedge clk);
         probe_ack = 1'b0;
         probe_free = 1'b0;
         if (fr || k == KICKS-1) begin
            chk("end_busy", int'(busy), 0);
            chk("end_probe_valid", int'(probe_valid), 0);
            break;
         end
      end
   endtask

   task automatic start_probe();
      rot_cw = 1'b1;
      @(negedge clk);
      rot_cw = 1'b0;
      chk("abort_probe_valid", int'(probe_valid), 1);
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;
      active = 1'b1;
      @(negedge clk);
      chk_zero("idle_after_reset");

      do_load(2);
      do_rot(0, 0);
      check_state("t_cw");
      do_load(6);
      do_rot(1, 0);
      check_state("l_ccw");
      do_load(0);
      do_rot(0, 2);
      do_rot(1, KICKS);
      check_state("after_reject");
      do_load(1);
      do_rot(0, 0);
      do_rot(1, 0);
      check_state("o_rot");
      do_load(7);

      do_load(4);
      start_probe();
      do_load(3);
      @(negedge clk);
      check_state("load_abort");

      start_probe();
      #2 rst_n = 1'b0;
      #1 chk_zero("async_reset_mid_probe");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_load(5);
      start_probe();
      active = 1'b0;
      @(negedge clk);
      chk_zero("inactive_mid_probe");
      model_reset();
      active = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) do_load(int'($urandom_range(0, 7)));
         do_rot(int'($urandom_range(0, 1)), int'($urandom_range(0, KICKS)));
      end
      repeat (3) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tetron_rotator.md
# tetron_rotator

Parametrised successor to the single-piece shaper. It holds the active tetromino's type and rotation state and produces registered block offsets for all seven pieces. Rotation requests go through a probe handshake with the board collision checker, with an optional horizontal wall-kick search before a rotation is committed. It sits between the input/game controller and the board/renderer, which add the offsets and the kick shift to the piece anchor.

## Interface
- OFF_W, 5, width of every signed two's-complement offset and shift; legal range 3..8.
- KICKS, 3, probe attempts per rotation request; legal range 1..5.

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- active  in  1  low = synchronous clear of all state/outputs to reset values
- load  in  1  load new piece; takes priority over everything but reset/!active
- load_type  in  3  0=I 1=O 2=T 3=S 4=Z 5=J 6=L; 7 = invalid, load ignored
- rot_cw / rot_ccw  in  1  rotation request, sampled in IDLE only
- probe_valid  out  1  candidate placement presented to checker
- probe_blkN_voffset / probe_blkN_hoffset (N=1..4)  out  OFF_W  candidate offsets
- probe_hshift  out  OFF_W  candidate horizontal kick applied to anchor
- probe_ack  in  1  checker result valid this cycle (only meaningful while probe_valid)
- probe_free  in  1  with ack: 1 = no collision
- blkN_voffset / blkN_hoffset (N=1..4)  out  OFF_W  committed offsets, blk1 = axis
- rotation  out  2  committed rotation state 0..3
- kick_hshift  out  OFF_W  shift committed by the last successful rotation, valid with done
- busy  out  1  high in PROBE
- done  out  1  one-cycle pulse ending a request
- rot_ok  out  1  qualifies done: 1 = committed, 0 = rejected

## Operation
- Coordinates: v grows down, h grows right. Each entry below is (v,h). All outputs are registered.
- Rotation-0 tables, listed blk1..blk4:
  - I: (0,0) (0,-1) (0,1) (0,2)
  - O: (0,0) (0,1) (1,0) (1,1)
  - T: (0,0) (0,-1) (0,1) (-1,0)
  - S: (0,0) (0,-1) (-1,0) (-1,1)
  - Z: (0,0) (0,1) (-1,0) (-1,-1)
  - J: (0,0) (0,-1) (0,1) (-1,-1)
  - L: (0,0) (0,-1) (0,1) (-1,1)
- Rotation r offsets = the rotation-0 table rotated CW r times.
  - CW maps (v,h) to (h,-v).
  - CCW maps (v,h) to (-h,v).
  - O ignores rotation; its offsets are constant.
- Rotation counter is mod 4: CW +1, CCW −1; 3→0 and 0→3 wrap.
- Kick sequence for attempt k = 0..KICKS-1: hshift = 0, −1, +1, −2, +2.
- FSM states: IDLE, PROBE.
- IDLE:
  - load with a valid type: latch type, rotation=0, table-0 offsets, kick_hshift=0.
  - Exactly one of rot_cw / rot_ccw, with a non-O piece: compute the candidate rotation, set k=0, go to PROBE.
  - Both rot_cw and rot_ccw high: no request.
  - O piece: no probe. rotation updates, offsets unchanged; done=1, rot_ok=1, kick_hshift=0 next cycle.
- PROBE:
  - probe_valid=1, probe offsets = candidate, probe_hshift = kick(k).
  - Outputs are held stable until ack.
  - ack & free: commit rotation, offsets and kick_hshift=kick(k); done=1, rot_ok=1; go to IDLE.
  - ack & !free, k<KICKS-1: k+1; probe_valid stays high with the new hshift.
  - ack & !free, k=KICKS-1: done=1, rot_ok=0; committed state unchanged; go to IDLE.
  - Rotation requests in PROBE are ignored (not queued).
  - load in PROBE aborts the probe: no done; load is applied; go to IDLE.
- Reset / !active: IDLE, all outputs 0 (busy=0, done=0, probe_valid=0, rotation=0), type = O.
  - Applies mid-probe too; the outstanding probe is dropped.

## Timing
- load sampled at edge N: offsets/rotation valid after edge N+1.
- Request sampled at edge N: probe_valid and busy high after N+1.
- Each ack with !free at edge M: the next hshift is presented after M+1. Minimum one cycle per attempt.
- Final ack at edge M: committed outputs, done and rot_ok update after M+1; busy low after M+1.
- done is high exactly one cycle. A new request is accepted in the done cycle.
- Best case request-to-commit: 2 cycles.

## Test plan
- Reset, then load T → rotation=0, blk2=(0,−1), blk3=(0,1), blk4=(−1,0), busy=0.
- T rot_cw, ack+free on first probe → probe_hshift=0; after commit rotation=1, blk2=(−1,0), blk3=(1,0), blk4=(0,1), done+rot_ok, kick_hshift=0.
- L rot_ccw from rotation 0 → rotation=3, blk2=(1,0), blk3=(−1,0), blk4=(−1,−1).
- KICKS=3, responses !free, !free, free → probe_hshift sequence 0, −1, +1; kick_hshift=+1, rot_ok=1.
- KICKS=3, all !free → single done with rot_ok=0; offsets and rotation unchanged.
- O rot_cw → no probe_valid; done next cycle. load during PROBE → no done, new piece at rotation 0. rst_n low mid-probe → all outputs 0 immediately.
